// File: rtl/ex_stage_mc_if.sv
// ex_stage_mc_if
//   Bundles every non-clock/reset signal of the execute stage.
//   master : decode/forwarding side (drives id_*, *_fwd, flush, out_ready)
//   slave  : the execute stage itself (drives in_ready, ex_*, out_valid, busy)
//   Upstream   : in_valid/in_ready, id_func, id_ctrl, id_pc_seq, id_a, id_b,
//                id_read2, id_dest, id_fwd_a, id_fwd_b
//   Forwarding : mem_fwd, wb_fwd (sampled live while the op sits in EX)
//   Control    : flush
//   Downstream : out_valid/out_ready, ex_ctrl, ex_pc_seq, ex_read2,
//                ex_result, ex_dest
//   Status     : busy (multiplier running)
interface ex_stage_mc_if #(
  parameter int W  = 32,
  parameter int RW = 5,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    id_func;
  logic [CW-1:0] id_ctrl;
  logic [W-1:0]  id_pc_seq;
  logic [W-1:0]  id_a;
  logic [W-1:0]  id_b;
  logic [W-1:0]  id_read2;
  logic [RW-1:0] id_dest;
  logic [1:0]    id_fwd_a;
  logic [1:0]    id_fwd_b;
  logic [W-1:0]  mem_fwd;
  logic [W-1:0]  wb_fwd;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] ex_ctrl;
  logic [W-1:0]  ex_pc_seq;
  logic [W-1:0]  ex_read2;
  logic [W-1:0]  ex_result;
  logic [RW-1:0] ex_dest;
  logic          busy;

  modport master (
    output in_valid, id_func, id_ctrl, id_pc_seq, id_a, id_b, id_read2,
           id_dest, id_fwd_a, id_fwd_b, mem_fwd, wb_fwd, flush, out_ready,
    input  in_ready, out_valid, ex_ctrl, ex_pc_seq, ex_read2, ex_result,
           ex_dest, busy
  );

  modport slave (
    input  in_valid, id_func, id_ctrl, id_pc_seq, id_a, id_b, id_read2,
           id_dest, id_fwd_a, id_fwd_b, mem_fwd, wb_fwd, flush, out_ready,
    output in_ready, out_valid, ex_ctrl, ex_pc_seq, ex_read2, ex_result,
           ex_dest, busy
  );
endinterface

// File: rtl/ex_stage_mc.sv
// ex_stage_mc
//   Execute stage: ID/EX holding register with valid/ready handshake,
//   MEM/WB operand forwarding, flush, single-cycle MIPS ALU ops and an
//   iterative shift-add multiplier (MULT/MULTU) writing HI/LO.
//   clk_i : clock
//   rst_i : asynchronous, active-high reset
//   bus   : ex_stage_mc_if.slave (handshakes, operands, results, busy)
module ex_stage_mc #(
  parameter int         W        = 32,
  parameter int         RW       = 5,
  parameter int         CW       = 8,
  parameter logic [7:0] CTRL_RST = 8'h31
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ex_stage_mc_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MUL} state_e;

  localparam logic [5:0]    F_MFHI      = 6'h10;
  localparam logic [5:0]    F_MFLO      = 6'h12;
  localparam logic [5:0]    F_MULT      = 6'h18;
  localparam logic [5:0]    F_MULTU     = 6'h19;
  localparam int            CNTW        = $clog2(W);
  localparam logic [CW-1:0] CTRL_BUBBLE = CW'(CTRL_RST);

  // 32-bit MIPS ALU; unknown function codes yield zero.
  function automatic logic [31:0] alu32(input logic [5:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    case (f)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24:        return a & b;
      6'h25:        return a | b;
      6'h26:        return a ^ b;
      6'h27:        return ~(a | b);
      6'h2a:        return {31'b0, $signed(a) < $signed(b)};
      6'h2b:        return {31'b0, a < b};
      6'h04:        return b << a[4:0];
      6'h06:        return b >> a[4:0];
      6'h07:        return $signed(b) >>> a[4:0];
      default:      return 32'b0;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic            v_q;
  logic [5:0]      func_q;
  logic [CW-1:0]   ctrl_q;
  logic [W-1:0]    pc_q, a_q, b_q, read2_q;
  logic [RW-1:0]   dest_q;
  logic [1:0]      fa_q, fb_q;
  logic [W-1:0]    hi_q, lo_q;
  logic [2*W-1:0]  mcand_q, acc_q;
  logic [W-1:0]    mplier_q;
  logic            neg_q;
  logic [CNTW-1:0] cnt_q;

  logic [W-1:0]    op_a, op_b, mag_a, mag_b, alu_res;
  logic [2*W-1:0]  acc_sum, prod;
  logic            is_mul, prod_neg, capture, mul_last;

  // Forwarded operands are resolved every cycle so a stalled op sees the
  // current MEM/WB values (upstream keeps them valid while stalled).
  always_comb begin
    case (fa_q)
      2'b01:   op_a = bus.mem_fwd;
      2'b10:   op_a = bus.wb_fwd;
      default: op_a = a_q;
    endcase
    case (fb_q)
      2'b01:   op_b = bus.mem_fwd;
      2'b10:   op_b = bus.wb_fwd;
      default: op_b = b_q;
    endcase
  end

  assign is_mul   = (func_q == F_MULT) || (func_q == F_MULTU);
  assign alu_res  = W'(alu32(func_q, 32'(op_a), 32'(op_b)));
  // Signed multiply runs on magnitudes; the sign is reapplied at the end.
  assign mag_a    = (func_q == F_MULT && op_a[W-1]) ? -op_a : op_a;
  assign mag_b    = (func_q == F_MULT && op_b[W-1]) ? -op_b : op_b;
  assign prod_neg = (func_q == F_MULT) && (op_a[W-1] ^ op_b[W-1]);
  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod     = neg_q ? -acc_sum : acc_sum;
  assign mul_last = (cnt_q == CNTW'(W - 1));

  assign bus.in_ready  = (state_q == S_IDLE) && (!v_q || bus.out_ready);
  assign bus.out_valid = v_q && (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign capture       = bus.in_valid && bus.in_ready && !bus.flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (capture && (bus.id_func == F_MULT || bus.id_func == F_MULTU))
                state_d = S_LOAD;
      S_LOAD: state_d = S_MUL;
      S_MUL:  if (mul_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      v_q      <= 1'b0;
      func_q   <= '0;
      ctrl_q   <= '0;
      pc_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      read2_q  <= '0;
      dest_q   <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (bus.flush) begin
        v_q <= 1'b0;
      end else if (capture) begin
        v_q     <= 1'b1;
        func_q  <= bus.id_func;
        ctrl_q  <= bus.id_ctrl;
        pc_q    <= bus.id_pc_seq;
        a_q     <= bus.id_a;
        b_q     <= bus.id_b;
        read2_q <= bus.id_read2;
        dest_q  <= bus.id_dest;
        fa_q    <= bus.id_fwd_a;
        fb_q    <= bus.id_fwd_b;
      end else if (bus.out_valid && bus.out_ready) begin
        v_q <= 1'b0;
      end

      // A flushed multiply must leave HI/LO untouched.
      if (!bus.flush) begin
        case (state_q)
          S_LOAD: begin
            mcand_q  <= {{W{1'b0}}, mag_a};
            mplier_q <= mag_b;
            acc_q    <= '0;
            neg_q    <= prod_neg;
            cnt_q    <= '0;
          end
          S_MUL: begin
            acc_q    <= acc_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (mul_last) begin
              hi_q <= prod[2*W-1:W];
              lo_q <= prod[W-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.ex_result = '0;
    if (v_q) begin
      case (func_q)
        F_MFHI:           bus.ex_result = hi_q;
        F_MFLO:           bus.ex_result = lo_q;
        F_MULT, F_MULTU:  bus.ex_result = '0;
        default:          bus.ex_result = alu_res;
      endcase
    end
  end

  // Multiplies never write a GPR, so they leave with dest 0.
  assign bus.ex_dest   = (v_q && !is_mul) ? dest_q : '0;
  assign bus.ex_ctrl   = v_q ? ctrl_q : CTRL_BUBBLE;
  assign bus.ex_pc_seq = v_q ? pc_q : '0;
  assign bus.ex_read2  = v_q ? read2_q : '0;
endmodule

// File: tb/tb_ex_stage_mc.sv
module tb_ex_stage_mc;
  localparam int W  = 32;
  localparam int RW = 5;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_stage_mc_if #(.W(W), .RW(RW), .CW(CW)) bus ();

  ex_stage_mc #(.W(W), .RW(RW), .CW(CW), .CTRL_RST(8'h31)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi, exp_lo;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  dest;
    logic [7:0]  ctrl;
    logic [31:0] pc;
  } exp_t;

  // Reference ALU from MIPS instruction semantics.
  function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (f)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2a: return (sa < sb) ? 32'd1 : 32'd0;
      6'h2b: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] fa, input logic [1:0] fb,
                          input logic [4:0] d, input logic [7:0] c);
    bus.in_valid  = 1'b1;
    bus.id_func   = f;
    bus.id_a      = a;
    bus.id_b      = b;
    bus.id_fwd_a  = fa;
    bus.id_fwd_b  = fb;
    bus.id_dest   = d;
    bus.id_ctrl   = c;
    bus.id_pc_seq = $urandom;
    bus.id_read2  = $urandom;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1;
    bus.id_func = 0; bus.id_ctrl = 0; bus.id_pc_seq = 0; bus.id_a = 0; bus.id_b = 0;
    bus.id_read2 = 0; bus.id_dest = 0; bus.id_fwd_a = 0; bus.id_fwd_b = 0;
    bus.mem_fwd = 0; bus.wb_fwd = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_hs got in_ready/out_valid/busy=%b want 100",
               {bus.in_ready, bus.out_valid, bus.busy});
    end
    n_checks++;
    if (bus.ex_ctrl !== 8'h31) begin
      n_fail++; $display("FAIL reset_ctrl got %h want 31", bus.ex_ctrl);
    end
    n_checks++;
    if ({bus.ex_result, bus.ex_dest, bus.ex_pc_seq, bus.ex_read2} !== '0) begin
      n_fail++; $display("FAIL reset_data got res=%h dest=%0d pc=%h r2=%h want all 0",
                         bus.ex_result, bus.ex_dest, bus.ex_pc_seq, bus.ex_read2);
    end
    $display("reset done");
  endtask

  task automatic test_forward();
    bus.out_ready = 1; bus.mem_fwd = 32'd7; bus.wb_fwd = 32'd9;
    drive_op(6'h20, 32'd5, 32'd0, 2'b00, 2'b01, 5'd3, 8'ha5);
    tick();
    drive_op(6'h20, 32'd5, 32'd0, 2'b00, 2'b10, 5'd4, 8'h5a);
    n_checks++;
    if (!bus.out_valid || bus.ex_result !== 32'd12 || bus.ex_dest !== 5'd3 || bus.ex_ctrl !== 8'ha5) begin
      n_fail++; $display("FAIL fwd_mem got v=%b res=%0d dest=%0d ctrl=%h want 1/12/3/a5",
                         bus.out_valid, bus.ex_result, bus.ex_dest, bus.ex_ctrl);
    end
    tick();
    drive_op(6'h22, 32'd0, 32'd3, 2'b01, 2'b00, 5'd5, 8'h11);
    n_checks++;
    if (!bus.out_valid || bus.ex_result !== 32'd14 || bus.ex_dest !== 5'd4) begin
      n_fail++; $display("FAIL fwd_wb got v=%b res=%0d dest=%0d want 1/14/4",
                         bus.out_valid, bus.ex_result, bus.ex_dest);
    end
    tick();
    bus.in_valid = 0;
    n_checks++;
    if (bus.ex_result !== 32'd4) begin
      n_fail++; $display("FAIL fwd_a_mem got %0d want 4", bus.ex_result);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.ex_ctrl !== 8'h31 || bus.ex_dest !== 5'd0 || bus.ex_result !== 32'd0) begin
      n_fail++; $display("FAIL bubble got v=%b ctrl=%h dest=%0d res=%h want 0/31/0/0",
                         bus.out_valid, bus.ex_ctrl, bus.ex_dest, bus.ex_result);
    end
    $display("forward done");
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      drive_op(6'h20, 32'(i), 32'(i), 2'b00, 2'b00, 5'(i), 8'h40);
      tick();
      n_checks++;
      if (!bus.out_valid || !bus.in_ready || bus.ex_result !== 32'(2 * i)) begin
        n_fail++; $display("FAIL b2b_%0d got v=%b rdy=%b res=%0d want 1/1/%0d",
                           i, bus.out_valid, bus.in_ready, bus.ex_result, 2 * i);
      end
      $display("b2b op %0d res=%0d", i, bus.ex_result);
    end
    bus.in_valid = 0;
    tick();
  endtask

  // Random stream with random back-pressure against a scoreboard queue.
  task automatic test_backpressure();
    exp_t q[$];
    exp_t held, e, got;
    logic held_v = 1'b0;
    logic accepted;
    int issued = 0, consumed = 0;
    logic [5:0] ops [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    bus.mem_fwd = $urandom; bus.wb_fwd = $urandom;
    drive_op(ops[$urandom_range(0, 9)], $urandom, $urandom, 2'($urandom), 2'($urandom),
             5'($urandom), 8'($urandom));
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      got = {bus.ex_result, bus.ex_dest, bus.ex_ctrl, bus.ex_pc_seq};
      if (held_v) begin
        n_checks++;
        if (got !== held || !bus.out_valid) begin
          n_fail++; $display("FAIL stall_hold got %h v=%b want %h v=1", got, bus.out_valid, held);
        end
      end
      held_v = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
          n_fail++; $display("FAIL stall_ready got %b want 0", bus.in_ready);
        end
        held = got; held_v = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra got %h want nothing", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            n_fail++; $display("FAIL stream_data got %h want %h", got, e);
          end
        end
        consumed++;
        $display("stream xfer %0d res=%h dest=%0d", consumed, got.res, got.dest);
      end
      accepted = bus.in_valid && bus.in_ready;
      if (accepted) begin
        e.res  = ref_alu(bus.id_func,
                         bus.id_fwd_a == 2'b01 ? bus.mem_fwd : bus.id_fwd_a == 2'b10 ? bus.wb_fwd : bus.id_a,
                         bus.id_fwd_b == 2'b01 ? bus.mem_fwd : bus.id_fwd_b == 2'b10 ? bus.wb_fwd : bus.id_b);
        e.dest = bus.id_dest; e.ctrl = bus.id_ctrl; e.pc = bus.id_pc_seq;
        q.push_back(e);
        issued++;
      end
      tick();
      if (accepted || !bus.in_valid) begin
        drive_op(ops[$urandom_range(0, 9)], $urandom, $urandom, 2'($urandom), 2'($urandom),
                 5'($urandom), 8'($urandom));
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid = 0; bus.out_ready = 1;
    for (int d = 0; d < 5; d++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = {bus.ex_result, bus.ex_dest, bus.ex_ctrl, bus.ex_pc_seq};
        n_checks++;
        e = (q.size() != 0) ? q.pop_front() : '0;
        if (got !== e) begin
          n_fail++; $display("FAIL drain_data got %h want %h", got, e);
        end
        consumed++;
      end
      tick();
    end
    n_checks++;
    if (consumed != issued || q.size() != 0) begin
      n_fail++; $display("FAIL stream_count got %0d out want %0d in (left %0d)",
                         consumed, issued, q.size());
    end
  endtask

  task automatic read_hilo(input logic [31:0] hi, input logic [31:0] lo, input string tag);
    bus.out_ready = 1;
    drive_op(6'h10, 32'd0, 32'd0, 2'b00, 2'b00, 5'd8, 8'h01);
    tick();
    drive_op(6'h12, 32'd0, 32'd0, 2'b00, 2'b00, 5'd9, 8'h02);
    n_checks++;
    if (!bus.out_valid || bus.ex_result !== hi || bus.ex_dest !== 5'd8) begin
      n_fail++; $display("FAIL %s_mfhi got v=%b res=%h dest=%0d want 1/%h/8",
                         tag, bus.out_valid, bus.ex_result, bus.ex_dest, hi);
    end
    tick();
    bus.in_valid = 0;
    n_checks++;
    if (!bus.out_valid || bus.ex_result !== lo) begin
      n_fail++; $display("FAIL %s_mflo got v=%b res=%h want 1/%h", tag, bus.out_valid, bus.ex_result, lo);
    end
    tick();
  endtask

  task automatic do_mult(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint signed sp;
    logic [63:0] p;
    int cycles = 0;
    logic bad = 1'b0;
    if (f == 6'h18) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      p = sp;
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    bus.out_ready = 1;
    drive_op(f, a, b, 2'b00, 2'b00, 5'd7, 8'h5c);
    tick();
    bus.in_valid = 0;
    while (bus.busy && cycles < 200) begin
      cycles++;
      if (bus.in_ready || bus.out_valid) bad = 1'b1;
      tick();
    end
    n_checks++;
    if (cycles != W + 1) begin
      n_fail++; $display("FAIL mult_busy got %0d cycles want %0d", cycles, W + 1);
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL mult_interlock got in_ready/out_valid high while busy want low");
    end
    n_checks++;
    if (!bus.out_valid || bus.ex_dest !== 5'd0 || bus.ex_result !== 32'd0 || bus.ex_ctrl !== 8'h5c) begin
      n_fail++; $display("FAIL mult_emit got v=%b dest=%0d res=%h ctrl=%h want 1/0/0/5c",
                         bus.out_valid, bus.ex_dest, bus.ex_result, bus.ex_ctrl);
    end
    exp_hi = p[63:32]; exp_lo = p[31:0];
    read_hilo(exp_hi, exp_lo, "mult");
    $display("mult f=%h %h x %h -> hi=%h lo=%h", f, a, b, exp_hi, exp_lo);
  endtask

  task automatic test_mult();
    do_mult(6'h18, 32'hffff_fffd, 32'd5);
    do_mult(6'h19, 32'hffff_ffff, 32'd2);
    do_mult(6'h18, 32'hffff_ffff, 32'd2);
    do_mult(6'h18, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 4; i++)
      do_mult(($urandom_range(0, 1) != 0) ? 6'h18 : 6'h19, $urandom, $urandom);
  endtask

  task automatic test_flush();
    do_mult(6'h19, 32'hffff_ffff, 32'd2);
    drive_op(6'h18, 32'd7, 32'd9, 2'b00, 2'b00, 5'd7, 8'h5c);
    tick();
    bus.in_valid = 0;
    repeat (9) tick();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre got busy=%b want 1", bus.busy);
    end
    bus.flush = 1;
    tick();
    bus.flush = 0;
    n_checks++;
    if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b010 || bus.ex_ctrl !== 8'h31) begin
      n_fail++; $display("FAIL flush_abort got busy/rdy/v=%b ctrl=%h want 010/31",
                         {bus.busy, bus.in_ready, bus.out_valid}, bus.ex_ctrl);
    end
    read_hilo(32'h1, 32'hffff_fffe, "flush");
    drive_op(6'h20, 32'd1, 32'd2, 2'b00, 2'b00, 5'd6, 8'h77);
    bus.flush = 1;
    tick();
    bus.flush = 0; bus.in_valid = 0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.ex_ctrl !== 8'h31) begin
      n_fail++; $display("FAIL flush_capture got v=%b ctrl=%h want 0/31", bus.out_valid, bus.ex_ctrl);
    end
    $display("flush done");
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1;
    drive_op(6'h18, 32'd3, 32'd3, 2'b00, 2'b00, 5'd7, 8'h5c);
    tick();
    bus.in_valid = 0;
    repeat (4) tick();
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100 || bus.ex_ctrl !== 8'h31 ||
        bus.ex_result !== 32'd0) begin
      n_fail++; $display("FAIL async_rst got rdy/v/busy=%b ctrl=%h res=%h want 100/31/0",
                         {bus.in_ready, bus.out_valid, bus.busy}, bus.ex_ctrl, bus.ex_result);
    end
    #2 rst = 1'b0;
    tick();
    drive_op(6'h20, 32'd1, 32'd1, 2'b00, 2'b00, 5'd2, 8'h03);
    tick();
    bus.in_valid = 0;
    n_checks++;
    if (!bus.out_valid || bus.ex_result !== 32'd2) begin
      n_fail++; $display("FAIL rst_add got v=%b res=%0d want 1/2", bus.out_valid, bus.ex_result);
    end
    tick();
    read_hilo(32'd0, 32'd0, "rst");
    $display("async reset done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_back_to_back();
    test_backpressure();
    test_mult();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised execute stage: ID/EX pipeline register with valid/ready handshaking, operand forwarding from MEM and WB, flush, and an iterative multiplier with HI/LO registers. Sits between decode and memory stages and replaces the fixed always-enabled execute register bank. Single-cycle ALU ops go through the existing `alu` block. MULT/MULTU stall the stage for W+1 cycles. MFHI/MFLO read the HI/LO registers.

## Interface
- W, 32, datapath width (even, ≥8)
- RW, 5, register-address width
- CW, 8, pass-through control width
- CTRL_RST, 8'h31, reset/bubble value of ex_ctrl (zero-extended or truncated to CW)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid / in_ready  in/out  1  upstream handshake; capture when both high
- id_func  in  6  function code (MIPS funct encoding)
- id_ctrl  in  CW  control bits passed downstream
- id_pc_seq, id_a, id_b, id_read2  in  W  sequential PC, operands, store data
- id_dest  in  RW  write-back register
- id_fwd_a, id_fwd_b  in  2  forward select: 00 reg, 01 MEM, 10 WB, 11 reg
- mem_fwd, wb_fwd  in  W  forwarded results, sampled live in EX cycle
- flush  in  1  kill instruction in EX
- out_valid / out_ready  out/in  1  downstream handshake
- ex_ctrl  out  CW;  ex_pc_seq, ex_read2, ex_result  out  W;  ex_dest  out  RW
- busy  out  1  multiplier running

## Operation
- Holding register: v, func, ctrl, pc_seq, a, b, read2, dest, fwd selects; load on in_valid&&in_ready.
- in_ready = state==IDLE && (!v || out_ready).
- Operands A/B = registered a/b or mem_fwd/wb_fwd per registered select, resolved combinationally each cycle.
- func 6'h10 MFHI → result HI; 6'h12 MFLO → LO; 6'h18 MULT, 6'h19 MULTU → multiply; all other codes → alu(func, A, B).
- FSM IDLE → LOAD → MUL → IDLE.
  - IDLE: on capture of 18/19 go LOAD.
  - LOAD (1 cycle): latch magnitudes |A|, |B| (MULT) or raw (MULTU), product sign, count=0. Forwarding is resolved here.
  - MUL: shift-add, one multiplier bit per cycle, 2W-bit accumulator. After W cycles write HI/LO (negate 2W result if sign set), go IDLE.
- out_valid = v && state==IDLE. For mult, ex_result=0 and ex_dest=0 (no GPR write); ctrl passed unchanged.
- busy = state!=IDLE.
- Stall: out_valid&&!out_ready holds all outputs and registered state stable. Forward data must stay valid upstream while stalled.
- flush (synchronous, highest priority): v←0, state←IDLE, no capture that cycle, HI/LO unchanged, ex_ctrl←CTRL_RST.
- Bubble (v=0): ex_ctrl=CTRL_RST, ex_dest=0, ex_result=0.
- Widths: alu used at 32 bits when W=32. For other W, alu result is zero-extended or truncated to W. HI/LO are W each.

## Timing
- Reset: v=0, state IDLE, HI=LO=0, ex_ctrl=CTRL_RST, all other outputs 0, in_ready=1, out_valid=0, busy=0.
- Single-cycle op captured at edge k: outputs valid after edge k.
- Back-to-back single-cycle ops: throughput 1 per clock when out_ready=1.
- Mult captured at edge k:
  - LOAD after edge k; MUL after edges k+1..k+W.
  - HI/LO written at edge k+W+1; out_valid after edge k+W+1.
  - in_ready=0 after edge k through edge k+W+1.
- MFHI immediately following a MULT reads the new HI (interlocked by in_ready).
- Reset during MUL: aborts, HI/LO=0.
- Flush during LOAD/MUL: aborts, HI/LO keep prior values, in_ready=1 next cycle.
- Flush and in_valid in the same cycle: input not captured.

## Test plan
- Forward: ADD (20) with id_a=5, id_fwd_b=01, mem_fwd=7 → ex_result=12 after one edge; with fwd_b=10, wb_fwd=9 → 14.
- Back-pressure: 3 ADDs streamed, out_ready low 2 cycles mid-stream → outputs held, in_ready low, no op lost or duplicated; order preserved.
- MULT A=-3 (FFFFFFFD), B=5 → busy for W+1 cycles, then MFHI=FFFFFFFF, MFLO=FFFFFFF1; mult itself emits dest=0.
- MULTU FFFFFFFF×2 → HI=00000001, LO=FFFFFFFE; MULT same operands → HI=FFFFFFFF, LO=FFFFFFFE.
- Flush at cycle 10 of a MULT following a completed HI=1 mult → busy drops next cycle, MFHI returns 1, new op accepted.
- Async reset asserted mid-MUL (between edges) → outputs immediately at reset values; after release, ADD 1+1 → 2.
